// File: rtl/ber_prbs_checker.sv
// PRBS generator and bit-error-rate checker.
// Generates a PRBS stream on tx_data, synchronises to a received PRBS stream,
// then counts checked bits and bit errors over a window of locked words.
// Optional feature: define BER_ERR_INJECT_EN to let an inject pulse flip
// bit 0 of the next transmitted word.
module ber_prbs_checker #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned PRBS_ORDER = 7,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned LOCK_WORDS = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  window_len,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              inject,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              locked,
    output logic              done,
    output logic              word_err,
    output logic [CNT_W-1:0]  bit_count,
    output logic [CNT_W-1:0]  err_count
);

    // Second feedback tap of x^N + x^T + 1
    localparam int unsigned TAP = (PRBS_ORDER == 7)  ? 6  :
                                  (PRBS_ORDER == 15) ? 14 :
                                  (PRBS_ORDER == 23) ? 18 : 28;
    localparam int unsigned MW        = $clog2(LOCK_WORDS + 1);
    localparam int unsigned PW        = $clog2(DATA_W + 1);
    localparam int unsigned ERR_LIMIT = DATA_W / 4;

    typedef enum logic [1:0] {IDLE, SYNC, LOCKED, DONE} state_t;

    state_t                state;
    logic [PRBS_ORDER-1:0] gen_state;
    logic [PRBS_ORDER-1:0] chk_state;
    logic [PRBS_ORDER-1:0] hist;
    logic [MW-1:0]         match_cnt;
    logic [MW-1:0]         miss_cnt;
    logic [CNT_W-1:0]      lw_count;

    // Next DATA_W sequence bits following a history (bit 0 = newest), MSB first
    function automatic logic [DATA_W-1:0] prbs_word(input logic [PRBS_ORDER-1:0] seed);
        logic [PRBS_ORDER-1:0] s;
        logic [DATA_W-1:0]     w;
        logic                  nb;
        s = seed;
        w = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            nb = s[PRBS_ORDER-1] ^ s[TAP-1];
            w  = {w[DATA_W-2:0], nb};
            s  = {s[PRBS_ORDER-2:0], nb};
        end
        return w;
    endfunction

    // Number of set bits in a word
    function automatic logic [PW-1:0] popcount(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] t;
        logic [PW-1:0]     c;
        t = v;
        c = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            c = c + PW'(t[0]);
            t = t >> 1;
        end
        return c;
    endfunction

    // Saturating add; sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    logic [DATA_W-1:0] seed_word;
    logic [DATA_W-1:0] gen_word;
    logic [DATA_W-1:0] exp_sync;
    logic [DATA_W-1:0] exp_lock;
    logic [PW-1:0]     err_pop;
    logic              sync_match;
    logic              bad_word;
    logic [CNT_W-1:0]  lw_next;
    logic              inj_bit;
    logic [DATA_W-1:0] inj_mask;

    assign seed_word  = prbs_word('1);
    assign gen_word   = prbs_word(gen_state);
    assign exp_sync   = prbs_word(hist);
    assign exp_lock   = prbs_word(chk_state);
    assign err_pop    = popcount(rx_data ^ exp_lock);
    assign sync_match = (hist != '0) && (rx_data == exp_sync);
    assign bad_word   = err_pop > PW'(ERR_LIMIT);
    assign lw_next    = sat_add(lw_count, CNT_W'(1));

`ifdef BER_ERR_INJECT_EN
    assign inj_bit = inject & (state != IDLE);
`else
    logic unused_inject;
    assign unused_inject = inject;
    assign inj_bit       = 1'b0;
`endif
    assign inj_mask = {{(DATA_W-1){1'b0}}, inj_bit};

    // Generator, synchroniser, lock tracking and counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gen_state <= '1;
            chk_state <= '1;
            hist      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            lw_count  <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            locked    <= 1'b0;
            done      <= 1'b0;
            word_err  <= 1'b0;
            bit_count <= '0;
            err_count <= '0;
        end else if (start) begin
            state     <= SYNC;
            gen_state <= seed_word[PRBS_ORDER-1:0];
            tx_data   <= seed_word ^ inj_mask;
            tx_valid  <= 1'b1;
            chk_state <= '1;
            hist      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            lw_count  <= '0;
            locked    <= 1'b0;
            done      <= 1'b0;
            word_err  <= 1'b0;
            bit_count <= '0;
            err_count <= '0;
        end else begin
            if (state != IDLE) begin
                tx_data   <= gen_word ^ inj_mask;
                gen_state <= gen_word[PRBS_ORDER-1:0];
            end
            if (rx_valid) begin
                case (state)
                    SYNC: begin
                        hist <= rx_data[PRBS_ORDER-1:0];
                        if (sync_match) begin
                            if (match_cnt == MW'(LOCK_WORDS - 1)) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                chk_state <= rx_data[PRBS_ORDER-1:0];
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                match_cnt <= match_cnt + MW'(1);
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        chk_state <= exp_lock[PRBS_ORDER-1:0];
                        bit_count <= sat_add(bit_count, CNT_W'(DATA_W));
                        err_count <= sat_add(err_count, CNT_W'(err_pop));
                        lw_count  <= lw_next;
                        if ((window_len != '0) && (lw_next >= window_len)) begin
                            state    <= DONE;
                            locked   <= 1'b0;
                            done     <= 1'b1;
                            word_err <= 1'b0;
                        end else if (bad_word && (miss_cnt == MW'(LOCK_WORDS - 1))) begin
                            state     <= SYNC;
                            locked    <= 1'b0;
                            word_err  <= 1'b0;
                            miss_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            word_err <= (err_pop != '0);
                            miss_cnt <= bad_word ? miss_cnt + MW'(1) : '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ber_prbs_checker.sv
// Self-checking bench for ber_prbs_checker (default parameters).
// Reference PRBS stream is built bit by bit from the polynomial recurrence.
module tb_ber_prbs_checker;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] window_len;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        inject;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        locked;
    logic        done;
    logic        word_err;
    logic [31:0] bit_count;
    logic [31:0] err_count;

    ber_prbs_checker dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .window_len (window_len),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .inject     (inject),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .locked     (locked),
        .done       (done),
        .word_err   (word_err),
        .bit_count  (bit_count),
        .err_count  (err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef BER_ERR_INJECT_EN
    localparam int N_INJ   = 3;
    localparam int INJ_EXP = 3;
`else
    localparam int N_INJ   = 10;
    localparam int INJ_EXP = 0;
`endif

    localparam int NWORDS = 1024;
    localparam int NB     = 7 + 16 * NWORDS;

    bit          bq [NB];
    logic [15:0] mw [NWORDS];

    int checks = 0;
    int errors = 0;
    int nvalid;
    int src_idx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Loopback one cycle: rx follows tx, optionally corrupted
    task automatic loop_cycle(input logic [15:0] flip);
        rx_data  = tx_data ^ flip;
        rx_valid = tx_valid;
        if (tx_valid) nvalid++;
        @(negedge clock);
    endtask

    // Drive one cycle from the reference stream; junk data when not valid
    task automatic src_cycle(input logic v, input logic [15:0] flip);
        rx_valid = v;
        if (v) begin
            rx_data = mw[src_idx] ^ flip;
            src_idx++;
        end else begin
            rx_data = 16'($urandom);
        end
        @(negedge clock);
    endtask

    task automatic do_start(input logic [31:0] wl);
        window_len = wl;
        rx_valid   = 1'b0;
        start      = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          lock_at;
        int          cnt;
        int          exp_bits;
        int          exp_err;
        int          we_cycles;
        logic        exp_we;
        logic        v;
        logic        ever;
        logic [15:0] flip;

        reset = 1'b1; start = 1'b0; inject = 1'b0;
        rx_valid = 1'b0; rx_data = '0; window_len = '0;

        // x^7 + x^6 + 1 from an all-ones seed; each word MSB first
        for (int n = 0; n < 7; n++) bq[n] = 1'b1;
        for (int n = 7; n < NB; n++) bq[n] = bq[n-7] ^ bq[n-6];
        for (int k = 0; k < NWORDS; k++)
            for (int i = 0; i < 16; i++)
                mw[k][15-i] = bq[7 + 16*k + i];

        repeat (2) @(negedge clock);
        chk("rst_tx_valid", 64'(tx_valid), 64'(0));
        chk("rst_tx_data", 64'(tx_data), 64'(0));
        chk("rst_locked", 64'(locked), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_word_err", 64'(word_err), 64'(0));
        chk("rst_bit_count", 64'(bit_count), 64'(0));
        chk("rst_err_count", 64'(err_count), 64'(0));
        reset = 1'b0;
        @(negedge clock);
        chk("idle_tx_valid", 64'(tx_valid), 64'(0));

        // Loopback, window of 100 locked words
        do_start(32'd100);
        nvalid = 0; lock_at = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            if (c < 8) chk("tx_word", 64'(tx_data), 64'(mw[c]));
            loop_cycle(16'h0);
            if (locked && lock_at == 0) lock_at = nvalid;
        end
        chk("lb_lock_after", 64'(lock_at), 64'(5));
        chk("lb_done", 64'(done), 64'(1));
        chk("lb_window_words", 64'(nvalid - lock_at), 64'(100));
        chk("lb_bit_count", 64'(bit_count), 64'(1600));
        chk("lb_err_count", 64'(err_count), 64'(0));
        repeat (5) loop_cycle(16'hFFFF);
        chk("done_hold", 64'(done), 64'(1));
        chk("done_locked", 64'(locked), 64'(0));
        chk("done_word_err", 64'(word_err), 64'(0));
        chk("done_tx_valid", 64'(tx_valid), 64'(1));
        chk("frozen_bits", 64'(bit_count), 64'(1600));
        chk("frozen_errs", 64'(err_count), 64'(0));

        // Sourced stream: two-bit error, random errors with gaps, loss of lock
        do_start(32'd0);
        src_idx = 0;
        for (int i = 0; i < 10 && !locked; i++) src_cycle(1'b1, 16'h0);
        chk("src_lock_words", 64'(src_idx), 64'(5));
        src_cycle(1'b1, 16'h0101);
        chk("two_bit_errs", 64'(err_count), 64'(2));
        chk("two_bit_word_err", 64'(word_err), 64'(1));
        chk("two_bit_bits", 64'(bit_count), 64'(16));
        src_cycle(1'b1, 16'h0);
        chk("clean_word_err", 64'(word_err), 64'(0));
        chk("clean_errs", 64'(err_count), 64'(2));
        exp_bits = 32; exp_err = 2; exp_we = 1'b0;
        for (int i = 0; i < 200; i++) begin
            v = ($urandom_range(3) != 0);
            flip = '0;
            if ($urandom_range(3) == 0) begin
                cnt = int'($urandom_range(4, 1));
                for (int k = 0; k < cnt; k++) flip = flip | (16'h1 << $urandom_range(15));
            end
            if (v) begin
                exp_bits += 16;
                exp_err  += $countones(flip);
                exp_we    = (flip != 16'h0);
            end
            src_cycle(v, flip);
            chk("rand_bits", 64'(bit_count), 64'(exp_bits));
            chk("rand_errs", 64'(err_count), 64'(exp_err));
            chk("rand_word_err", 64'(word_err), 64'(exp_we));
            chk("rand_locked", 64'(locked), 64'(1));
        end
        for (int i = 0; i < 4; i++) begin
            flip = 16'h001F << $urandom_range(11);
            exp_bits += 16;
            exp_err  += 5;
            src_cycle(1'b1, flip);
            chk("loss_locked", 64'(locked), 64'(i < 3 ? 1 : 0));
        end
        chk("loss_bits_hold", 64'(bit_count), 64'(exp_bits));
        chk("loss_errs_hold", 64'(err_count), 64'(exp_err));
        chk("loss_word_err", 64'(word_err), 64'(0));
        cnt = 0;
        for (int i = 0; i < 8 && !locked; i++) begin
            src_cycle(1'b1, 16'h0);
            cnt++;
        end
        chk("relock_within5", 64'(locked && cnt <= 5), 64'(1));
        chk("relock_bits", 64'(bit_count), 64'(exp_bits));

        // Start arriving with the final window word
        do_start(32'd10);
        src_idx = 100;
        for (int i = 0; i < 10 && !locked; i++) src_cycle(1'b1, 16'h0);
        chk("win_locked", 64'(locked), 64'(1));
        for (int i = 0; i < 9; i++) src_cycle(1'b1, 16'h0);
        chk("win_not_done", 64'(done), 64'(0));
        chk("win_bits9", 64'(bit_count), 64'(144));
        rx_valid = 1'b1; rx_data = mw[src_idx]; src_idx++;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("startwin_done", 64'(done), 64'(0));
        chk("startwin_locked", 64'(locked), 64'(0));
        chk("startwin_bits", 64'(bit_count), 64'(0));
        chk("startwin_tx_valid", 64'(tx_valid), 64'(1));
        for (int i = 0; i < 5; i++) src_cycle(1'b1, 16'h0);
        chk("startwin_relock", 64'(locked), 64'(1));
        chk("startwin_bits0", 64'(bit_count), 64'(0));

        // All-zero input never locks
        do_start(32'd0);
        rx_data = '0; rx_valid = 1'b1; ever = 1'b0;
        repeat (1000) begin
            @(negedge clock);
            if (locked) ever = 1'b1;
        end
        chk("zeros_never_locked", 64'(ever), 64'(0));
        chk("zeros_bits", 64'(bit_count), 64'(0));
        chk("zeros_errs", 64'(err_count), 64'(0));

        // Reset mid-LOCKED, then restart
        do_start(32'd0);
        src_idx = 200;
        for (int i = 0; i < 10 && !locked; i++) src_cycle(1'b1, 16'h0);
        for (int i = 0; i < 20; i++) src_cycle(1'b1, (i == 3) ? 16'h8000 : 16'h0);
        chk("pre_reset_errs", 64'(err_count), 64'(1));
        reset = 1'b1;
        #1;
        chk("mid_rst_tx_valid", 64'(tx_valid), 64'(0));
        chk("mid_rst_tx_data", 64'(tx_data), 64'(0));
        chk("mid_rst_locked", 64'(locked), 64'(0));
        chk("mid_rst_bits", 64'(bit_count), 64'(0));
        chk("mid_rst_errs", 64'(err_count), 64'(0));
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        do_start(32'd0);
        src_idx = 400; cnt = 0;
        for (int i = 0; i < 8 && !locked; i++) begin
            src_cycle(1'b1, 16'h0);
            cnt++;
        end
        chk("rst_relock_words", 64'(cnt), 64'(5));
        chk("rst_relock_bits", 64'(bit_count), 64'(0));
        src_cycle(1'b1, 16'h0);
        chk("rst_relock_bits16", 64'(bit_count), 64'(16));

        // Error injection over loopback
        do_start(32'd0);
        nvalid = 0;
        repeat (10) loop_cycle(16'h0);
        chk("inj_locked", 64'(locked), 64'(1));
        chk("inj_errs_before", 64'(err_count), 64'(0));
        we_cycles = 0;
        for (int p = 0; p < N_INJ; p++) begin
            inject = 1'b1;
            loop_cycle(16'h0);
            if (word_err) we_cycles++;
            inject = 1'b0;
            repeat (3) begin
                loop_cycle(16'h0);
                if (word_err) we_cycles++;
            end
        end
        repeat (3) begin
            loop_cycle(16'h0);
            if (word_err) we_cycles++;
        end
        chk("inj_errs", 64'(err_count), 64'(INJ_EXP));
        chk("inj_word_err_cycles", 64'(we_cycles), 64'(INJ_EXP));
        chk("inj_lock_held", 64'(locked), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ber_prbs_checker.md
BER_PRBS_CHECKER -- requirements
Module: ber_prbs_checker

Interface
REQ-001 Parameter DATA_W, default 16: bits per word; SHALL be at least PRBS_ORDER.
REQ-002 Parameter PRBS_ORDER, default 7: legal values 7, 15, 23, 31.
REQ-003 Parameter CNT_W, default 32: width of the bit and error counters.
REQ-004 Parameter LOCK_WORDS, default 4: consecutive words needed to lock or to lose lock.
REQ-005 clock  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse; clears the counters and begins synchronisation.
REQ-008 window_len  in  CNT_W  number of locked words to test; 0 means run until the next start or reset.
REQ-009 rx_data  in  DATA_W  received word.
REQ-010 rx_valid  in  1  rx_data is valid this cycle.
REQ-011 inject  in  1  error-injection request pulse.
REQ-012 tx_data  out  DATA_W  generated PRBS word; MSB is first in time.
REQ-013 tx_valid  out  1  high in every state except IDLE.
REQ-014 locked  out  1  high while the state is LOCKED.
REQ-015 done  out  1  high while the state is DONE.
REQ-016 word_err  out  1  registered; the last checked word had at least one error.
REQ-017 bit_count  out  CNT_W  total bits checked.
REQ-018 err_count  out  CNT_W  total bits in error.

Function
REQ-019 Generator: a Fibonacci LFSR advances DATA_W bits per cycle while tx_valid is high; it is seeded to all-ones on reset and on start.
REQ-020 Polynomials: x^7+x^6+1, x^15+x^14+1, x^23+x^18+1, x^31+x^28+1, chosen by PRBS_ORDER.
REQ-021 States: IDLE, SYNC, LOCKED, DONE; reset places the FSM in IDLE.
REQ-022 start moves the FSM from any state to SYNC, reseeds the generator, and zeroes the counters, word_err and the match/miss counters.
REQ-023 SYNC: the expected word is the LFSR continuation of the last PRBS_ORDER bits of the previous valid rx_data.
- A matching word increments the match counter; a mismatch clears it.
- A word whose history is all zeros never counts as a match.
REQ-024 SYNC to LOCKED: on the LOCK_WORDS-th consecutive match; the checker LFSR is loaded from the rx history on the same edge.
REQ-025 LOCKED: the expected word comes from the free-running checker LFSR, which advances only when rx_valid is high.
- bit_count increases by DATA_W for each valid word.
- err_count increases by popcount(rx_data XOR expected) for each valid word.
- Both updates are visible 1 cycle after the word.
REQ-026 Counters saturate at all-ones and do not wrap.
REQ-027 Loss of lock: after LOCK_WORDS consecutive valid words each with more than DATA_W/4 bit errors, the FSM returns to SYNC; counters hold their values.
REQ-028 LOCKED to DONE: when the locked-word count reaches a non-zero window_len; the counters then freeze and done holds until start or reset.
REQ-029 While rx_valid is low there is no count update, no LFSR advance in the checker, and no state transition.
REQ-030 If start and the final window word arrive in the same cycle, start wins: the FSM goes to SYNC and the counters clear.
REQ-031 word_err is updated only on valid words in LOCKED and is 0 in every other state.

Reset
REQ-032 While reset is high: FSM in IDLE, generator and checker LFSRs all-ones, tx_data=0, and tx_valid, locked, done, word_err, bit_count, err_count all 0.
REQ-033 Reset asserted mid-operation SHALL abort immediately and discard all counts.

Configuration
REQ-034 Macro BER_ERR_INJECT_EN defined: an inject pulse inverts bit 0 of the next tx_data word emitted, exactly once per pulse; pulses in IDLE are ignored.
REQ-035 Macro undefined: the inject port remains, is ignored, and tx_data is never corrupted.

Verification
REQ-036 Loopback tx_data to rx_data, defaults, window_len=100 -> locked after 5 valid words, done after 100 locked words, bit_count=1600, err_count=0.
REQ-037 Macro defined, loopback, 3 inject pulses while LOCKED, window_len=0 -> err_count=3, lock held, word_err high for exactly 3 cycles.
REQ-038 Flip 2 bits of one rx word while LOCKED -> err_count=2 one cycle later, word_err high for one cycle.
REQ-039 rx_data held at 0 with rx_valid=1 for 1000 cycles -> locked stays 0, both counters stay 0.
REQ-040 Reset pulse mid-LOCKED -> all outputs 0; after start, locked again within 5 valid words with counters restarted from 0.
REQ-041 Macro undefined, loopback, inject pulsed 10 times -> err_count=0.
